// File: rtl/vc_test_sink_arb.sv
// rtl/vc_test_sink_arb.sv - round-robin burst arbiter sharing one test sink among val/rdy producers
// Define VC_TEST_SINK_ARB_STATS_EN to add the per-requester accepted-message counters on `stats`.
module vc_test_sink_arb #(
  parameter int p_msg_nbits = 8,
  parameter int p_num_reqs  = 4,
  parameter int p_id_nbits  = $clog2(p_num_reqs),
  parameter int p_max_burst = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_num_reqs-1:0]             in_val,
  output logic [p_num_reqs-1:0]             in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [p_id_nbits+p_msg_nbits-1:0] out_msg
`ifdef VC_TEST_SINK_ARB_STATS_EN
  ,
  output logic [p_num_reqs*16-1:0]          stats
`endif
);

  typedef enum logic {ARB, LOCK} state_t;

  localparam logic [3:0]            lp_max_burst = 4'(p_max_burst);
  localparam logic [p_id_nbits-1:0] lp_last_id   = p_id_nbits'(p_num_reqs - 1);
  localparam logic [p_id_nbits-1:0] lp_one       = p_id_nbits'(1);

  state_t                          r_state, w_state_nxt;
  logic [p_id_nbits-1:0]           r_ptr, w_ptr_nxt;
  logic [p_id_nbits-1:0]           r_owner, w_owner_nxt;
  logic [3:0]                      r_bcnt, w_bcnt_nxt;
  logic                            r_out_val;
  logic [p_id_nbits+p_msg_nbits-1:0] r_out_msg;

  logic                            w_can_accept;
  logic                            w_found;
  logic                            w_xfer;
  logic [p_id_nbits-1:0]           w_winner;
  logic [p_id_nbits-1:0]           w_sel;
  logic [p_id_nbits-1:0]           w_owner_inc;
  logic [p_id_nbits-1:0]           w_winner_inc;
  logic [p_num_reqs-1:0]           w_rdy;

  assign w_can_accept = !r_out_val || out_rdy;
  assign w_owner_inc  = (r_owner == lp_last_id) ? '0 : r_owner + lp_one;
  assign w_winner_inc = (w_winner == lp_last_id) ? '0 : w_winner + lp_one;

  // Scan from the highest offset down so the closest valid requester after ptr wins.
  always_comb begin
    int                    v_sum;
    logic [p_id_nbits-1:0] v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_sum    = 0;
    v_idx    = '0;
    for (int k = p_num_reqs - 1; k >= 0; k--) begin
      v_sum = int'(r_ptr) + k;
      if (v_sum >= p_num_reqs) v_sum = v_sum - p_num_reqs;
      v_idx = p_id_nbits'(v_sum);
      if (in_val[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  always_comb begin
    w_rdy       = '0;
    w_sel       = w_winner;
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      ARB: begin
        if (w_found) w_rdy[w_winner] = w_can_accept;
        if (w_found && w_can_accept) begin
          if (p_max_burst > 1) begin
            w_state_nxt = LOCK;
            w_owner_nxt = w_winner;
            w_bcnt_nxt  = 4'd1;
          end else begin
            w_ptr_nxt = w_winner_inc;
          end
        end
      end
      LOCK: begin
        w_sel          = r_owner;
        w_rdy[r_owner] = w_can_accept && in_val[r_owner];
        // An idle owner only releases when the buffer could have taken a beat.
        if (w_can_accept) begin
          if (in_val[r_owner]) begin
            w_bcnt_nxt = r_bcnt + 4'd1;
            if (r_bcnt + 4'd1 == lp_max_burst) begin
              w_state_nxt = ARB;
              w_ptr_nxt   = w_owner_inc;
            end
          end else begin
            w_state_nxt = ARB;
            w_ptr_nxt   = w_owner_inc;
          end
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  assign w_xfer  = |(w_rdy & in_val);
  assign in_rdy  = reset ? w_rdy : '0;
  assign out_val = r_out_val;
  assign out_msg = r_out_msg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ARB;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_bcnt    <= '0;
      r_out_val <= 1'b0;
      r_out_msg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_bcnt  <= w_bcnt_nxt;
      if (w_can_accept) begin
        r_out_val <= w_xfer;
        if (w_xfer) r_out_msg <= {w_sel, in_msg[w_sel*p_msg_nbits +: p_msg_nbits]};
      end
    end
  end

`ifdef VC_TEST_SINK_ARB_STATS_EN
  logic [p_num_reqs*16-1:0] r_stats;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stats <= '0;
    end else begin
      for (int i = 0; i < p_num_reqs; i++) begin
        if (w_rdy[i] && in_val[i] && (r_stats[i*16 +: 16] != 16'hFFFF))
          r_stats[i*16 +: 16] <= r_stats[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign stats = r_stats;
`else
  // Counters absent; arbitration is unaffected.
`endif

endmodule
